// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and the keyboard receiver.
// Both ends of the link use the same frame layout and command set.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RELEASE,
      ST_SEND,
      ST_ACK
   } state_t;

   localparam logic [7:0] CMD_LEDS   = 8'hED;
   localparam logic [7:0] CMD_RESET  = 8'hFF;
   localparam logic [7:0] CMD_ENABLE = 8'hF4;
   localparam logic [7:0] ACK_BYTE   = 8'hFA;

   // A full frame is start + 8 data + parity + stop; the start bit is driven
   // separately, so the shift register holds the remaining bits.
   localparam int unsigned FRAME_LEN  = 11;
   localparam int unsigned FRAME_BITS = FRAME_LEN - 1;

   // {stop, odd parity, data}, shifted out LSB first
   function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] d);
      return {1'b1, ~^d, d};
   endfunction

endpackage

// File: rtl/ps2_filter.sv
// PS/2 line conditioning: 2-FF synchronisers on clock and data, a glitch
// filter on the clock line and a one-ce-tick falling-edge pulse.
module ps2_filter #(
   parameter int unsigned FILTER = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic i_ce,
   input  logic i_ck,
   input  logic i_d,
   output logic o_fall,
   output logic o_d
);

   localparam int unsigned FW = (FILTER > 1) ? $clog2(FILTER) : 1;

   logic [1:0]    r_ck_s;
   logic [1:0]    r_d_s;
   logic [FW-1:0] r_cnt;
   logic          r_level;
   logic          r_fall;

   // Synchronisers run every clock; idle lines are high
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ck_s <= 2'b11;
         r_d_s  <= 2'b11;
      end else begin
         r_ck_s <= {r_ck_s[0], i_ck};
         r_d_s  <= {r_d_s[0], i_d};
      end
   end

   // Level changes only after FILTER consecutive disagreeing samples
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_level <= 1'b1;
         r_fall  <= 1'b0;
      end else if (i_ce) begin
         r_fall <= 1'b0;
         if (r_ck_s[1] != r_level) begin
            if (r_cnt == FW'(FILTER - 1)) begin
               r_level <= r_ck_s[1];
               r_cnt   <= '0;
               r_fall  <= r_level;
            end else begin
               r_cnt <= r_cnt + FW'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_fall = r_fall;
   assign o_d    = r_d_s[1];

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, presents the start bit,
// shifts a command byte out on device clock falls and checks the ack bit.
module ps2_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT = 840,
   parameter int unsigned TIMEOUT = 105000,
   parameter int unsigned FILTER  = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ce,
   input  logic       start,
   input  logic [7:0] data,
   output logic       busy,
   output logic       done,
   output logic       error,
   input  logic       ps2ckI,
   input  logic       ps2dI,
   output logic       ps2ckOe,
   output logic       ps2dOe
);

   localparam int unsigned TMAX = (INHIBIT > TIMEOUT) ? INHIBIT : TIMEOUT;
   localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int unsigned CW   = $clog2(FRAME_BITS + 1);

   state_t                r_state,  w_state_nxt;
   logic [CW-1:0]         r_cnt,    w_cnt_nxt;
   logic [TW-1:0]         r_timer,  w_timer_nxt;
   logic [FRAME_BITS-1:0] r_frame,  w_frame_nxt;
   logic                  r_busy,   w_busy_nxt;
   logic                  r_done,   w_done_nxt;
   logic                  r_error,  w_error_nxt;
   logic                  r_ckoe,   w_ckoe_nxt;
   logic                  r_doe,    w_doe_nxt;
   logic                  w_fall;
   logic                  w_d_sync;

   ps2_filter #(.FILTER(FILTER)) u_filter (
      .clock  (clock),
      .reset  (reset),
      .i_ce   (ce),
      .i_ck   (ps2ckI),
      .i_d    (ps2dI),
      .o_fall (w_fall),
      .o_d    (w_d_sync)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_timer <= '0;
         r_frame <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
         r_ckoe  <= 1'b0;
         r_doe   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_timer <= w_timer_nxt;
         r_frame <= w_frame_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_error <= w_error_nxt;
         r_ckoe  <= w_ckoe_nxt;
         r_doe   <= w_doe_nxt;
      end
   end

   // Everything holds while ce=0, so pulses stay exactly one ce tick wide
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_timer_nxt = r_timer;
      w_frame_nxt = r_frame;
      w_busy_nxt  = r_busy;
      w_done_nxt  = r_done;
      w_error_nxt = r_error;
      w_ckoe_nxt  = r_ckoe;
      w_doe_nxt   = r_doe;
      if (ce) begin
         w_done_nxt  = 1'b0;
         w_error_nxt = 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               w_busy_nxt = 1'b0;
               w_ckoe_nxt = 1'b0;
               w_doe_nxt  = 1'b0;
               if (start) begin
                  w_frame_nxt = make_frame(data);
                  w_cnt_nxt   = '0;
                  w_timer_nxt = '0;
                  w_busy_nxt  = 1'b1;
                  w_ckoe_nxt  = 1'b1;
                  w_state_nxt = ST_INHIBIT;
               end
            end
            ST_INHIBIT: begin
               if (r_timer == TW'(INHIBIT - 1)) begin
                  w_doe_nxt   = 1'b1;
                  w_timer_nxt = '0;
                  w_state_nxt = ST_RELEASE;
               end else begin
                  w_timer_nxt = r_timer + TW'(1);
               end
            end
            ST_RELEASE: begin
               // Falls caused by our own inhibit are ignored here
               w_ckoe_nxt  = 1'b0;
               w_timer_nxt = '0;
               w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
               if (w_fall) begin
                  w_doe_nxt   = ~r_frame[0];
                  w_frame_nxt = {1'b0, r_frame[FRAME_BITS-1:1]};
                  w_cnt_nxt   = r_cnt + CW'(1);
                  w_timer_nxt = '0;
                  if (r_cnt == CW'(FRAME_BITS - 1))
                     w_state_nxt = ST_ACK;
               end else if (r_timer == TW'(TIMEOUT - 1)) begin
                  w_ckoe_nxt  = 1'b0;
                  w_doe_nxt   = 1'b0;
                  w_busy_nxt  = 1'b0;
                  w_error_nxt = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_timer_nxt = r_timer + TW'(1);
               end
            end
            ST_ACK: begin
               if (w_fall) begin
                  w_done_nxt  = ~w_d_sync;
                  w_error_nxt = w_d_sync;
                  w_busy_nxt  = 1'b0;
                  w_doe_nxt   = 1'b0;
                  w_ckoe_nxt  = 1'b0;
                  w_state_nxt = ST_IDLE;
               end else if (r_timer == TW'(TIMEOUT - 1)) begin
                  w_ckoe_nxt  = 1'b0;
                  w_doe_nxt   = 1'b0;
                  w_busy_nxt  = 1'b0;
                  w_error_nxt = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_timer_nxt = r_timer + TW'(1);
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign error   = r_error;
   assign ps2ckOe = r_ckoe;
   assign ps2dOe  = r_doe;

endmodule
